// File: rtl/shift_sub_div.sv
// shift_sub_div -- sequential restoring divider.
//
// Divides a 2*WIDTH-bit unsigned dividend by a WIDTH-bit unsigned divisor and
// produces one quotient bit per clock. It shares the start/done handshake of
// shift_add_mult, so one controller can drive both blocks.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      request; only a rising edge is acted on, and it may be held high
//   dividend   2*WIDTH-bit numerator, sampled on the accepting edge
//   divisor    WIDTH-bit denominator, sampled on the accepting edge
//   busy       high while an iteration is in progress
//   done       result valid; holds until the next accepted start
//   err        divide-by-zero or quotient overflow; valid while done is high
//   quotient   WIDTH-bit result register
//   remainder  WIDTH-bit result register
//
// Build option
//   SHIFT_SUB_DIV_ABORT_EN  when defined, a start edge during RUN restarts the
//                           operation with freshly sampled operands. When
//                           undefined, start edges during RUN are ignored.
module shift_sub_div #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_nxt;
  logic                 start_q;
  logic                 start_edge;
  logic                 accept;
  logic                 bad_req;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [WIDTH-1:0]     rem, rem_nxt;
  logic [WIDTH-1:0]     q, q_nxt;
  logic [WIDTH-1:0]     dsr, dsr_nxt;
  logic                 busy_nxt, done_nxt, err_nxt;
  logic [WIDTH-1:0]     quotient_nxt, remainder_nxt;
  logic [WIDTH-1:0]     rem_step, q_step;

  // One restoring iteration. The trial value t is WIDTH+1 bits; because the
  // running remainder is always below the divisor, t - dsr fits in WIDTH bits
  // whenever the subtraction is taken, so only the low bits are kept.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] r,
    input logic [WIDTH-1:0] qq,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH:0]   t;
    logic             ge;
    logic [WIDTH-1:0] rn;
    t  = {r, qq[WIDTH-1]};
    ge = (t >= {1'b0, d});
    rn = ge ? (t[WIDTH-1:0] - d) : t[WIDTH-1:0];
    return {rn, qq[WIDTH-2:0], ge};
  endfunction

  assign start_edge = start & ~start_q;
  // A zero divisor or a high half not below the divisor would need more than
  // WIDTH quotient bits (or is undefined), so it is flagged without iterating.
  assign bad_req    = (divisor == '0) || (dividend[2*WIDTH-1:WIDTH] >= divisor);

`ifdef SHIFT_SUB_DIV_ABORT_EN
  assign accept = start_edge;
`else
  assign accept = start_edge && (state == IDLE);
`endif

  assign {rem_step, q_step} = div_step(rem, q, dsr);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    rem_nxt       = rem;
    q_nxt         = q;
    dsr_nxt       = dsr;
    busy_nxt      = busy;
    done_nxt      = done;
    err_nxt       = err;
    quotient_nxt  = quotient;
    remainder_nxt = remainder;
    if (accept) begin
      done_nxt = 1'b0;
      err_nxt  = 1'b0;
      if (bad_req) begin
        state_nxt     = IDLE;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b1;
        err_nxt       = 1'b1;
        quotient_nxt  = '1;
        remainder_nxt = '0;
      end else begin
        state_nxt = RUN;
        busy_nxt  = 1'b1;
        rem_nxt   = dividend[2*WIDTH-1:WIDTH];
        q_nxt     = dividend[WIDTH-1:0];
        dsr_nxt   = divisor;
        cnt_nxt   = CW'(WIDTH);
      end
    end else if (state == RUN) begin
      rem_nxt = rem_step;
      q_nxt   = q_step;
      cnt_nxt = cnt - 1'b1;
      if (cnt == CW'(1)) begin
        state_nxt     = IDLE;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b1;
        err_nxt       = 1'b0;
        quotient_nxt  = q_step;
        remainder_nxt = rem_step;
      end
    end
  end

  // Control and result registers. start_q tracks start even during reset so a
  // start held high across reset release is not seen as a new request.
  always_ff @(posedge clk) begin
    start_q <= start;
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      quotient  <= quotient_nxt;
      remainder <= remainder_nxt;
    end
  end

  // Working registers; only meaningful while in RUN, so they carry no reset.
  always_ff @(posedge clk) begin
    cnt <= cnt_nxt;
    rem <= rem_nxt;
    q   <= q_nxt;
    dsr <= dsr_nxt;
  end

endmodule
